instr_encoder: RTL
==================

# instr_encoder

- Streaming RV32I instruction encoder, the inverse of the `decode` stage: accepts instruction fields (class, `ALU_*` operation, registers, immediate) and emits the 32-bit `instr_raw` word.
- Used by the boot/test-program loader to fill instruction memory: each emitted word carries the byte address it is to be written to.
- Two-stage valid/ready pipeline with immediate range checking and an address counter.

## Interface
- ADDR_W, 10, width of the output byte address.
- ADDR_BASE, 0, address of the first emitted word after reset.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept; transfer when in_valid && in_ready.
- kind  in  4  class: 0 LW, 1 SW, 2 OP, 3 OP_IMM, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal.
- alu_op  in  4  `ALU_*` code from def.v; selects funct3/funct7 for OP, OP_IMM, BRANCH; ignored for other kinds.
- rd, rs1, rs2  in  5 each  register indices; unused fields of a format are ignored.
- imm  in  32  signed immediate as `decode` would reproduce it: byte offset for B/J; full value with low 12 bits zero for U.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- instr_raw  out  32  encoded word.
- addr  out  ADDR_W  byte address of instr_raw.
- err  out  1  the current output word came from an illegal request.

## Operation
- Stage 1 registers the accepted fields; stage 2 performs the encoding into the output registers (instr_raw, err, out_valid).
- Encodings follow RV32I: LW funct3 010, SW funct3 010. OP: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, funct7 0100000 for SUB/SRA.
  - OP_IMM: ADD/SLT/SLTU/XOR/OR/AND/SLL/SRL/SRA. Shifts place imm[4:0] in bits 24:20, and bit 30 is set for SRA.
  - BRANCH: SEQ→BEQ, SNE→BNE, SLT→BLT, SGE→BGE, SLTU→BLTU, SGEU→BGEU.
  - JALR funct3 000.
- Illegal, err=1:
  - kind 9-15.
  - alu_op not listed for its kind, e.g. SUB under OP_IMM, ADD under BRANCH.
  - I/S imm outside [-2048, 2047].
  - Shift imm outside [0, 31].
  - B imm outside [-4096, 4094] or odd.
  - J imm outside [-2^20, 2^20-2] or odd.
  - U imm[11:0] ≠ 0.
- Illegal requests emit instr_raw = 32'h0000_0013 (NOP) with err=1. Addressing is unchanged.
- addr starts at ADDR_BASE. After each output transfer it adds 4, modulo 2^ADDR_W, wrapping silently.

## Timing
- Reset values:
  - out_valid 0, instr_raw 0, err 0, addr ADDR_BASE.
  - Both stages empty; in_ready 1 once reset deasserts.
- Latency: a word accepted on edge N is presented with out_valid=1 after edge N+1.
- Throughput one word/cycle while out_ready=1.
- Stall rules:
  - Stage 2 holds while out_valid && !out_ready; instr_raw, addr and err stay stable.
  - Stage 1 advances when stage 2 is empty or transferring.
  - in_ready = !s1_valid || !(out_valid && !out_ready), combinational. At most 2 words in flight.
- Simultaneous accept and output transfer on the same edge is legal and loses nothing.
- out_valid never drops without a transfer.
- Reset asserted mid-stream drops all in-flight words and restores reset values immediately, without waiting for a clock edge.

## Test plan
- OP_IMM/ADD rd=1 rs1=0 imm=5, out_ready=1 → 0x00500093 at addr 0, err 0. Then LUI rd=5 imm=0x12345000 → 0x123452B7 at addr 4.
- OP/SUB rd=3 rs1=1 rs2=2 → 0x402081B3. SW rs1=1 rs2=2 imm=8 → 0x0020A423. BRANCH/SEQ rs1=1 rs2=2 imm=-4 → 0xFE208EE3.
- OP_IMM/ADD imm=4096; BRANCH imm=3; kind=12 → each 0x00000013 with err 1; addresses still advance by 4.
- Back-to-back 4 words with out_ready low for 3 cycles after the first out_valid:
  - in_ready drops with 2 words held; first word stable throughout.
  - All 4 words delivered in order at consecutive addresses.
- ADDR_W=4, ADDR_BASE=12: two words → addr 12 then 0 (wrap).
- Assert reset while 2 words are in flight → out_valid 0 and addr ADDR_BASE before the next edge. Next accepted word appears at ADDR_BASE.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction encoder (inverse of decode).
// Stage 1 registers the accepted instruction fields. Stage 2 encodes them
// into instr_raw/err and tags the word with its instruction-memory byte
// address. Requests that cannot be encoded become a NOP flagged with err.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   kind, alu_op          instruction class and ALU operation code
//   rd, rs1, rs2, imm     register indices and signed immediate
//   out_valid / out_ready output handshake
//   instr_raw, addr, err  encoded word, its byte address, illegal-request flag
module instr_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned ADDR_BASE = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        kind,
    input  logic [3:0]        alu_op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr_raw,
    output logic [ADDR_W-1:0] addr,
    output logic              err
);

    // Instruction classes
    localparam logic [3:0] K_LW     = 4'd0;
    localparam logic [3:0] K_SW     = 4'd1;
    localparam logic [3:0] K_OP     = 4'd2;
    localparam logic [3:0] K_OPIMM  = 4'd3;
    localparam logic [3:0] K_BRANCH = 4'd4;
    localparam logic [3:0] K_JAL    = 4'd5;
    localparam logic [3:0] K_JALR   = 4'd6;
    localparam logic [3:0] K_LUI    = 4'd7;
    localparam logic [3:0] K_AUIPC  = 4'd8;

    // ALU_* operation codes shared with decode
    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_SLL  = 4'd2;
    localparam logic [3:0] A_SLT  = 4'd3;
    localparam logic [3:0] A_SLTU = 4'd4;
    localparam logic [3:0] A_XOR  = 4'd5;
    localparam logic [3:0] A_SRL  = 4'd6;
    localparam logic [3:0] A_SRA  = 4'd7;
    localparam logic [3:0] A_OR   = 4'd8;
    localparam logic [3:0] A_AND  = 4'd9;
    localparam logic [3:0] A_SEQ  = 4'd10;
    localparam logic [3:0] A_SNE  = 4'd11;
    localparam logic [3:0] A_SGE  = 4'd12;
    localparam logic [3:0] A_SGEU = 4'd13;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  F7_ALT     = 7'b0100000;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    logic        s1_valid_q;
    logic [3:0]  s1_kind_q, s1_op_q;
    logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [31:0] s1_imm_q;

    logic              out_valid_q, err_q;
    logic [31:0]       raw_q;
    logic [ADDR_W-1:0] addr_q;

    logic        s2_adv, in_fire, out_fire;
    logic [31:0] raw_d;
    logic        err_d;

    assign out_fire  = out_valid_q && out_ready;
    assign s2_adv    = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign instr_raw = raw_q;
    assign err       = err_q;
    assign addr      = addr_q;

    // Immediate range checks: value fits when all bits above the field are sign copies
    logic i_fits, b_fits, j_fits, sh_fits, u_fits;
    assign i_fits  = (&s1_imm_q[31:11]) || (~|s1_imm_q[31:11]);
    assign b_fits  = ((&s1_imm_q[31:12]) || (~|s1_imm_q[31:12])) && !s1_imm_q[0];
    assign j_fits  = ((&s1_imm_q[31:20]) || (~|s1_imm_q[31:20])) && !s1_imm_q[0];
    assign sh_fits = ~|s1_imm_q[31:5];
    assign u_fits  = ~|s1_imm_q[11:0];

    // Encoder for the word held in stage 1
    logic        legal, is_shift;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] word;
    always_comb begin
        legal    = 1'b0;
        is_shift = 1'b0;
        f3       = 3'b000;
        f7       = 7'b0000000;
        word     = 32'h0;
        case (s1_kind_q)
            K_LW: begin
                legal = i_fits;
                word  = {s1_imm_q[11:0], s1_rs1_q, 3'b010, s1_rd_q, OPC_LOAD};
            end
            K_SW: begin
                legal = i_fits;
                word  = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, 3'b010, s1_imm_q[4:0], OPC_STORE};
            end
            K_OP: begin
                legal = 1'b1;
                case (s1_op_q)
                    A_ADD:  f3 = 3'b000;
                    A_SUB:  begin f3 = 3'b000; f7 = F7_ALT; end
                    A_SLL:  f3 = 3'b001;
                    A_SLT:  f3 = 3'b010;
                    A_SLTU: f3 = 3'b011;
                    A_XOR:  f3 = 3'b100;
                    A_SRL:  f3 = 3'b101;
                    A_SRA:  begin f3 = 3'b101; f7 = F7_ALT; end
                    A_OR:   f3 = 3'b110;
                    A_AND:  f3 = 3'b111;
                    default: legal = 1'b0;
                endcase
                word = {f7, s1_rs2_q, s1_rs1_q, f3, s1_rd_q, OPC_OP};
            end
            K_OPIMM: begin
                legal = i_fits;
                case (s1_op_q)
                    A_ADD:  f3 = 3'b000;
                    A_SLT:  f3 = 3'b010;
                    A_SLTU: f3 = 3'b011;
                    A_XOR:  f3 = 3'b100;
                    A_OR:   f3 = 3'b110;
                    A_AND:  f3 = 3'b111;
                    A_SLL:  begin f3 = 3'b001; is_shift = 1'b1; legal = sh_fits; end
                    A_SRL:  begin f3 = 3'b101; is_shift = 1'b1; legal = sh_fits; end
                    A_SRA:  begin f3 = 3'b101; f7 = F7_ALT; is_shift = 1'b1; legal = sh_fits; end
                    default: legal = 1'b0;
                endcase
                // Shifts carry shamt in 24:20 with funct7 above it
                word = is_shift ? {f7, s1_imm_q[4:0], s1_rs1_q, f3, s1_rd_q, OPC_OPIMM}
                                : {s1_imm_q[11:0], s1_rs1_q, f3, s1_rd_q, OPC_OPIMM};
            end
            K_BRANCH: begin
                legal = b_fits;
                case (s1_op_q)
                    A_SEQ:  f3 = 3'b000;
                    A_SNE:  f3 = 3'b001;
                    A_SLT:  f3 = 3'b100;
                    A_SGE:  f3 = 3'b101;
                    A_SLTU: f3 = 3'b110;
                    A_SGEU: f3 = 3'b111;
                    default: legal = 1'b0;
                endcase
                word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, f3,
                        s1_imm_q[4:1], s1_imm_q[11], OPC_BRANCH};
            end
            K_JAL: begin
                legal = j_fits;
                word  = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                         s1_rd_q, OPC_JAL};
            end
            K_JALR: begin
                legal = i_fits;
                word  = {s1_imm_q[11:0], s1_rs1_q, 3'b000, s1_rd_q, OPC_JALR};
            end
            K_LUI: begin
                legal = u_fits;
                word  = {s1_imm_q[31:12], s1_rd_q, OPC_LUI};
            end
            K_AUIPC: begin
                legal = u_fits;
                word  = {s1_imm_q[31:12], s1_rd_q, OPC_AUIPC};
            end
            default: legal = 1'b0;
        endcase
        raw_d = legal ? word : NOP_WORD;
        err_d = !legal;
    end

    // Stage 1: capture fields; empties when stage 2 takes the word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_kind_q  <= 4'd0;
            s1_op_q    <= 4'd0;
            s1_rd_q    <= 5'd0;
            s1_rs1_q   <= 5'd0;
            s1_rs2_q   <= 5'd0;
            s1_imm_q   <= 32'd0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_kind_q  <= kind;
            s1_op_q    <= alu_op;
            s1_rd_q    <= rd;
            s1_rs1_q   <= rs1;
            s1_rs2_q   <= rs2;
            s1_imm_q   <= imm;
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: output registers and address counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            raw_q       <= 32'd0;
            err_q       <= 1'b0;
            addr_q      <= ADDR_W'(ADDR_BASE);
        end else begin
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    raw_q <= raw_d;
                    err_q <= err_d;
                end
            end
            if (out_fire) begin
                addr_q <= addr_q + ADDR_W'(4);
            end
        end
    end

endmodule
